// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : 2^AW x WIDTH register file, two combinational read ports,
//                one clocked write port, r[0] hardwired to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile #(
   parameter int WIDTH  = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr1,
   output logic [WIDTH-1:0] rdata1,
   input  logic [AW-1:0]    raddr2,
   output logic [WIDTH-1:0] rdata2
);

   localparam int NREG = 1 << AW;

   logic [NREG-1:0]       w_wsel;
   logic [NREG*WIDTH-1:0] w_flat;
   logic [WIDTH-1:0]      w_stored1;
   logic [WIDTH-1:0]      w_stored2;
   logic                  w_hit1;
   logic                  w_hit2;

   // One-hot write decode; slot 0 never gets an enable.
   always_comb begin
      w_wsel        = '0;
      w_wsel[waddr] = wen;
      w_wsel[0]     = 1'b0;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign w_flat[gi*WIDTH +: WIDTH] = '0;
         end else begin : g_word
            logic [WIDTH-1:0] word_q;
            logic [WIDTH-1:0] word_d;

            always_comb begin
               word_d = word_q;
               if (w_wsel[gi]) begin
                  word_d = wdata;
               end
            end

            always_ff @(posedge clk) begin
               if (rst) begin
                  word_q <= '0;
               end else begin
                  word_q <= word_d;
               end
            end

            assign w_flat[gi*WIDTH +: WIDTH] = word_q;
         end
      end
   endgenerate

   assign w_stored1 = w_flat[raddr1*WIDTH +: WIDTH];
   assign w_stored2 = w_flat[raddr2*WIDTH +: WIDTH];

   // Forwarding is suppressed under reset so reads show the stored contents.
   generate
      if (BYPASS != 0) begin : g_bypass
         assign w_hit1 = wen && !rst && (waddr == raddr1) && (waddr != '0);
         assign w_hit2 = wen && !rst && (waddr == raddr2) && (waddr != '0);
      end else begin : g_nobypass
         assign w_hit1 = 1'b0;
         assign w_hit2 = 1'b0;
      end
   endgenerate

   always_comb begin
      rdata1 = w_stored1;
      if (raddr1 == '0) begin
         rdata1 = '0;
      end else if (w_hit1) begin
         rdata1 = wdata;
      end
   end

   always_comb begin
      rdata2 = w_stored2;
      if (raddr2 == '0) begin
         rdata2 = '0;
      end else if (w_hit2) begin
         rdata2 = wdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile
//  Description : Bench for regfile; BYPASS=1 and BYPASS=0 copies share inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   regfile #(.WIDTH(32), .AW(5), .BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(rd1_b), .raddr2(raddr2), .rdata2(rd2_b)
   );

   regfile #(.WIDTH(32), .AW(5), .BYPASS(0)) dut_n (
      .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(rd1_n), .raddr2(raddr2), .rdata2(rd2_n)
   );

   // Reference contents: a plain array updated by the architectural rules.
   logic [31:0] mem [32];
   bit          valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] = 32'h0;
         valid = 1'b1;
      end else if (wen && waddr != 5'd0) begin
         mem[waddr] = wdata;
      end
   end

   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
      if (a == 5'd0) return 32'h0;
      if (byp && wen && !rst && waddr == a) return wdata;
      return mem[a];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (valid) begin
         check("model_p1_byp", rd1_b, exp_rd(raddr1, 1'b1));
         check("model_p2_byp", rd2_b, exp_rd(raddr2, 1'b1));
         check("model_p1_nobyp", rd1_n, exp_rd(raddr1, 1'b0));
         check("model_p2_nobyp", rd2_n, exp_rd(raddr2, 1'b0));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
      step();
      rst = 1'b0;

      // Reset clears a previously written register
      wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      step();
      wen = 1'b0; raddr1 = 5'd5; #1;
      check("pre_reset_r5", rd1_n, 32'hDEADBEEF);
      rst = 1'b1;
      step();
      rst = 1'b0; #1;
      check("reset_r5_byp", rd1_b, 32'h0);
      check("reset_r5_nobyp", rd1_n, 32'h0);

      // Successive writes, read on both ports
      wen = 1'b1; waddr = 5'd3; wdata = 32'h12345678;
      step();
      waddr = 5'd31; wdata = 32'hFFFFFFFF;
      step();
      wen = 1'b0; raddr1 = 5'd3; raddr2 = 5'd31; #1;
      check("wr_r3", rd1_b, 32'h12345678);
      check("wr_r31", rd2_b, 32'hFFFFFFFF);
      check("wr_r3_nobyp", rd1_n, 32'h12345678);

      // Register 0 ignores writes, even through bypass
      wen = 1'b1; waddr = 5'd0; wdata = 32'hAAAA5555; raddr1 = 5'd0; raddr2 = 5'd0; #1;
      check("r0_during_p1", rd1_b, 32'h0);
      check("r0_during_p2", rd2_b, 32'h0);
      step();
      wen = 1'b0; #1;
      check("r0_after_p1", rd1_b, 32'h0);
      check("r0_after_p2", rd2_n, 32'h0);

      // Bypass vs no bypass on the write cycle
      wen = 1'b1; waddr = 5'd7; wdata = 32'h1;
      step();
      waddr = 5'd7; wdata = 32'h2; raddr1 = 5'd7; raddr2 = 5'd7; #1;
      check("byp_before_edge", rd1_b, 32'h2);
      check("byp_before_edge_p2", rd2_b, 32'h2);
      check("nobyp_before_edge", rd1_n, 32'h1);
      step();
      wen = 1'b0; #1;
      check("byp_after_edge", rd1_b, 32'h2);
      check("nobyp_after_edge", rd1_n, 32'h2);

      // Reset priority over a simultaneous write; bypass disabled under reset
      wen = 1'b1; waddr = 5'd9; wdata = 32'h11;
      step();
      rst = 1'b1; wen = 1'b1; waddr = 5'd9; wdata = 32'h55; raddr1 = 5'd9; #1;
      check("rst_no_bypass", rd1_b, 32'h11);
      check("rst_no_bypass_n", rd1_n, 32'h11);
      step();
      rst = 1'b0; wen = 1'b0;
      for (int a = 0; a < 32; a++) begin
         raddr1 = a[4:0]; raddr2 = 5'(31 - a); #1;
         check("sweep_p1", rd1_b, 32'h0);
         check("sweep_p2", rd2_n, 32'h0);
      end

      // wen low keeps contents
      wen = 1'b0; waddr = 5'd4; wdata = 32'h77; raddr1 = 5'd4;
      repeat (3) step();
      check("wen_low_r4", rd1_b, 32'h0);
      check("wen_low_r4_n", rd1_n, 32'h0);

      // Randomised traffic, checked every cycle against the reference array
      for (int c = 0; c < 600; c++) begin
         rst   = ($urandom_range(0, 59) == 0);
         wen   = $urandom_range(0, 2) != 0;
         waddr = 5'($urandom);
         wdata = $urandom;
         raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
         raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom);
         step();
      end
      rst = 1'b0; wen = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
